// File: rtl/tdc_pkg.sv
// Shared types for the TDC capture/decode path: control encodings, decoder FSM states
// and a majority helper used by the optional bubble corrector.
package tdc_pkg;

  typedef enum logic {
    PG_IN  = 1'b0,
    PG_TOG = 1'b1
  } ctrl_pulse_src_t;

  typedef enum logic {
    BYPASS = 1'b0,
    REG    = 1'b1
  } ctrl_bypass_t;

  typedef enum logic [1:0] {
    DEC_IDLE   = 2'd0,
    DEC_SYNC   = 2'd1,
    DEC_DECODE = 2'd2,
    DEC_HOLD   = 2'd3
  } tdc_dec_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_lead_ones_enc.sv
// Combinational leading-ones counter: number of consecutive 1s from tap 0 (0..N_TAPS).
// Zero latency, no flow control; bits above the first 0 are ignored.
module tdc_lead_ones_enc #(
  parameter int N_TAPS = 32,
  parameter int CODE_W = $clog2(N_TAPS + 1)
) (
  input  logic [N_TAPS-1:0] taps,
  output logic [CODE_W-1:0] code
);

  logic run;

  always_comb begin
    code = '0;
    run  = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (run && taps[i]) begin
        code = CODE_W'(i + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdc_therm_decoder.sv
// TDC tap capture, polarity normalisation and thermometer decode; optional TDC_BUBBLE_CORR_EN.
// Latency 2 cycles (BYPASS) or 3 (REG); one measurement in flight, strobes while busy are counted as missed.
module tdc_therm_decoder
  import tdc_pkg::*;
#(
  parameter int N_TAPS = 32,
  parameter int CODE_W = $clog2(N_TAPS + 1),
  parameter int MISS_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ctrl_pulse_src_t       ctl_pls_src_i,
  input  ctrl_bypass_t          ctl_bypass_i,
  input  logic [N_TAPS-1:0]     taps_i,
  input  logic                  sample_i,
  output logic [CODE_W-1:0]     code_o,
  output logic                  code_valid_o,
  input  logic                  code_ready_i,
  output logic                  overflow_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic [MISS_W-1:0]     miss_cnt_o
);

  tdc_dec_state_t    state;
  logic [N_TAPS-1:0] cap1;
  logic [N_TAPS-1:0] cap2;
  logic [N_TAPS-1:0] norm;
  logic [N_TAPS-1:0] corr;
  logic [CODE_W-1:0] enc_code;
  ctrl_bypass_t      byp_q;
  logic              pol;
  logic              pol_q;

  assign busy_o = (state != DEC_IDLE);

  always_comb begin
    norm = ((byp_q == BYPASS) ? cap1 : cap2) ^ {N_TAPS{~pol_q}};
  end

`ifdef TDC_BUBBLE_CORR_EN
  // Virtual boundary taps: a 1 before tap 0 and a 0 past the last tap.
  logic [N_TAPS+1:0] ext;
  assign ext = {1'b0, norm, 1'b1};

  always_comb begin
    corr = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      corr[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
  end
`else
  assign corr = norm;
`endif

  tdc_lead_ones_enc #(
    .N_TAPS (N_TAPS),
    .CODE_W (CODE_W)
  ) u_enc (
    .taps (corr),
    .code (enc_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DEC_IDLE;
      cap1         <= '0;
      cap2         <= '0;
      byp_q        <= BYPASS;
      pol          <= 1'b1;
      pol_q        <= 1'b1;
      code_o       <= '0;
      code_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
      zero_o       <= 1'b0;
      miss_cnt_o   <= '0;
    end else begin
      // The launcher flips its edge on every strobe, whether or not we take the sample.
      if (sample_i && (ctl_pls_src_i == PG_TOG)) begin
        pol <= ~pol;
      end
      if (sample_i && (state != DEC_IDLE) && (miss_cnt_o != '1)) begin
        miss_cnt_o <= miss_cnt_o + 1'b1;
      end
      case (state)
        DEC_IDLE: begin
          if (sample_i) begin
            cap1  <= taps_i;
            byp_q <= ctl_bypass_i;
            pol_q <= (ctl_pls_src_i == PG_TOG) ? pol : 1'b1;
            state <= (ctl_bypass_i == REG) ? DEC_SYNC : DEC_DECODE;
          end
        end
        DEC_SYNC: begin
          cap2  <= cap1;
          state <= DEC_DECODE;
        end
        DEC_DECODE: begin
          code_o       <= enc_code;
          overflow_o   <= (enc_code == CODE_W'(N_TAPS));
          zero_o       <= (enc_code == '0);
          code_valid_o <= 1'b1;
          state        <= DEC_HOLD;
        end
        DEC_HOLD: begin
          if (code_ready_i) begin
            code_valid_o <= 1'b0;
            state        <= DEC_IDLE;
          end
        end
        default: state <= DEC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder: expected codes queued at strobe time, compared on handshake.
// Expectations for the bubble case follow TDC_BUBBLE_CORR_EN.
module tb_tdc_therm_decoder;
  import tdc_pkg::*;

  localparam int N_TAPS = 32;
  localparam int CODE_W = $clog2(N_TAPS + 1);
  localparam int MISS_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  ctrl_pulse_src_t   ctl_pls_src = PG_IN;
  ctrl_bypass_t      ctl_bypass = BYPASS;
  logic [N_TAPS-1:0] taps = '0;
  logic              sample = 1'b0;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready = 1'b1;
  logic              overflow;
  logic              zero;
  logic              busy;
  logic [MISS_W-1:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int mon_exp;

  always #5 clk = ~clk;

  tdc_therm_decoder #(
    .N_TAPS (N_TAPS),
    .CODE_W (CODE_W),
    .MISS_W (MISS_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctl_pls_src_i (ctl_pls_src),
    .ctl_bypass_i  (ctl_bypass),
    .taps_i        (taps),
    .sample_i      (sample),
    .code_o        (code),
    .code_valid_o  (code_valid),
    .code_ready_i  (code_ready),
    .overflow_o    (overflow),
    .zero_o        (zero),
    .busy_o        (busy),
    .miss_cnt_o    (miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every handshake pops one expected code.
  always @(negedge clk) begin
    if (!rst && code_valid && code_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("code", 32'(code), 32'(mon_exp));
        check("overflow", 32'(overflow), 32'(mon_exp == N_TAPS));
        check("zero", 32'(zero), 32'(mon_exp == 0));
      end
    end
  end

  task automatic strobe(input logic [31:0] t, input ctrl_bypass_t b, input ctrl_pulse_src_t s, input int exp_code);
    @(negedge clk);
    taps        = t;
    ctl_bypass  = b;
    ctl_pls_src = s;
    sample      = 1'b1;
    exp_q.push_back(exp_code);
    @(negedge clk);
    sample      = 1'b0;
    ctl_bypass  = (b == REG) ? BYPASS : REG;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!code_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run_one(input string tag, input logic [31:0] t, input ctrl_bypass_t b,
                         input ctrl_pulse_src_t s, input int exp_code, input int exp_lat);
    strobe(t, b, s, exp_code);
    wait_valid({tag, "_lat"}, exp_lat);
    @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  int bub_exp;

  initial begin
`ifdef TDC_BUBBLE_CORR_EN
    bub_exp = 8;
`else
    bub_exp = 3;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    check("rst_ovf_zero", {30'd0, overflow, zero}, 32'd0);
    rst = 1'b0;

    run_one("byp_ff", 32'h0000_00FF, BYPASS, PG_IN, 8, 2);
    run_one("reg_ff", 32'h0000_00FF, REG, PG_IN, 8, 3);
    run_one("tog_a", 32'h0000_0FFF, BYPASS, PG_TOG, 12, 2);
    run_one("tog_b", 32'hFFFF_FF00, BYPASS, PG_TOG, 8, 2);
    run_one("bubble", 32'h0000_00F7, BYPASS, PG_IN, bub_exp, 2);
    run_one("all_ones", 32'hFFFF_FFFF, REG, PG_IN, 32, 3);
    run_one("all_zero", 32'h0000_0000, BYPASS, PG_IN, 0, 2);

    // Backpressure: three strobes while holding a result.
    code_ready = 1'b0;
    strobe(32'h0000_000F, BYPASS, PG_IN, 4);
    wait_valid("bp_lat", 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
      check("bp_hold_code", 32'(code), 32'd4);
      check("bp_hold_valid", 32'(code_valid), 32'd1);
    end
    check("miss_3", 32'(miss_cnt), 32'd3);
    @(negedge clk);
    code_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle", 32'(busy), 32'd0);

    // Saturation: 297 more dropped strobes brings the total to 300.
    code_ready = 1'b0;
    strobe(32'h0000_0003, BYPASS, PG_IN, 2);
    wait_valid("sat_lat", 2);
    sample = 1'b1;
    repeat (297) @(negedge clk);
    sample = 1'b0;
    @(negedge clk);
    check("miss_sat", 32'(miss_cnt), 32'd255);

    // Reset while holding a result.
    check("pre_rst_valid", 32'(code_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_hold_valid", 32'(code_valid), 32'd0);
    check("rst_hold_miss", 32'(miss_cnt), 32'd0);
    check("rst_hold_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    code_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_output", 32'(code_valid), 32'd0);

    run_one("post_rst", 32'h0000_007F, BYPASS, PG_IN, 7, 2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_therm_decoder.md
Name: tdc_therm_decoder

Overview:
Capture and decode end of the TDC delay line. The pulse generator launches an edge into the delay line; this block samples the tap vector on a strobe and normalises its polarity for toggle mode. It then bubble-corrects the taps, encodes them to a binary tap count, and presents the result on a valid/ready interface to the readout logic. It honours the existing pulse-source and bypass control lines.

Parameters:
N_TAPS, 32, number of delay-line taps sampled.
CODE_W, $clog2(N_TAPS+1), width of decoded code (0..N_TAPS).
MISS_W, 8, width of saturating missed-sample counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
ctl_pls_src_i  input  ctrl_pulse_src_t  PG_IN: fixed polarity; PG_TOG: polarity alternates per sample.
ctl_bypass_i  input  ctrl_bypass_t  BYPASS: single capture stage; REG: extra resync stage.
taps_i  input  N_TAPS  raw delay-line taps, tap 0 nearest launch point.
sample_i  input  1  one-cycle strobe: taps_i are to be sampled.
code_o  output  CODE_W  decoded leading-ones count.
code_valid_o  output  1  code_o valid.
code_ready_i  input  1  consumer accepts code.
overflow_o  output  1  code_o == N_TAPS (edge ran past the last tap).
zero_o  output  1  code_o == 0.
busy_o  output  1  FSM not in IDLE.
miss_cnt_o  output  MISS_W  saturating count of strobes dropped while busy.

Behaviour:
- Reset (async, rst=1): state IDLE; code_o=0; code_valid_o=0; overflow_o=0; zero_o=0; busy_o=0; miss_cnt_o=0; expected polarity pol=1; capture regs=0. Reset mid-operation aborts the measurement. No output is produced afterwards.
- FSM states: IDLE, SYNC, DECODE, HOLD.
  - IDLE + sample_i:
    - Register taps_i.
    - Latch ctl_bypass_i and ctl_pls_src_i for this measurement. Later changes to these inputs do not affect it.
    - Go to SYNC if REG, else DECODE.
  - SYNC: second register stage. Next state is DECODE.
  - DECODE:
    - XOR the taps with ~pol.
    - Bubble-correct, then encode.
    - Register code_o and set code_valid_o. Go to HOLD.
  - HOLD: hold code_o and code_valid_o stable until code_valid_o && code_ready_i. Then clear valid and go to IDLE. A sample_i in that same cycle is dropped (not accepted).
- Latency: sample_i in cycle 0 gives code_valid_o in cycle 2 (BYPASS) or cycle 3 (REG).
- Throughput: one measurement in flight. Any sample_i while state != IDLE increments miss_cnt_o. The counter saturates at 2^MISS_W-1 and clears only on reset.
- Polarity:
  - PG_IN: pol stays 1.
  - PG_TOG: pol toggles on every sample_i, accepted or dropped, because the launcher toggles regardless.
  - pol reloads to 1 on reset only.
- Encoding:
  - code = number of consecutive 1s starting at tap 0, after normalisation and correction. Range is 0..N_TAPS.
  - Bits above the first 0 are ignored.
- overflow_o and zero_o are registered together with code_o and are valid only while code_valid_o is high.

Optional Feature:
TDC_BUBBLE_CORR_EN.
- Defined: each normalised tap is replaced by majority(t[i-1], t[i], t[i+1]), with boundary t[-1]=1 and t[N_TAPS]=0. This is done in DECODE and adds no latency.
- Undefined: raw normalised taps feed the encoder directly.

Decomposition:
- Add to tdc_pkg:
  - enum tdc_dec_state_t {DEC_IDLE, DEC_SYNC, DEC_DECODE, DEC_HOLD}.
  - Reuse ctrl_pulse_src_t and ctrl_bypass_t.
- One sub-module, tdc_lead_ones_enc: combinational N_TAPS-to-CODE_W leading-ones priority encoder, parameterised by N_TAPS.

Test Plan:
- BYPASS, PG_IN, taps=0x000000FF, sample at cycle 0, ready=1 -> code_valid_o high in cycle 2, code_o=8; returns to IDLE the next cycle.
- REG, same taps -> code_valid_o in cycle 3, code_o=8. Switching ctl_bypass_i to BYPASS at cycle 1 does not change the latency.
- PG_TOG, two samples:
  - First, taps=0x00000FFF -> code 12.
  - Second, taps=0xFFFFFF00 (inverted polarity) -> code 8.
- taps=0x000000F7 (bubble at bit 3) -> code 8 with TDC_BUBBLE_CORR_EN, code 3 without.
- Boundary tap values:
  - taps=0xFFFFFFFF -> code 32, overflow_o=1.
  - taps=0x00000000 -> code 0, zero_o=1.
- Backpressure and reset:
  - Hold ready=0 in HOLD and issue 3 samples -> miss_cnt_o=3; code_o stays unchanged.
  - 300 dropped samples -> miss_cnt_o=255.
  - Assert rst mid-HOLD -> code_valid_o=0 immediately, miss_cnt_o=0.
